// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-wide SRAM with configurable wait states.
// Out-of-range, oversized or misaligned transfers receive the two-cycle ERROR response.
`timescale 1ns/1ps
module ahb_sram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e r_state;
  state_e w_nextState;
  state_e w_launch;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [IDX_W-1:0]      r_idx;
  logic [OFF_W-1:0]      r_off;
  logic [2:0]            r_size;
  logic                  r_write;
  logic [WCNT_W-1:0]     r_waitCnt;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [ADDR_WIDTH-1:0] w_offs;
  logic [ADDR_WIDTH-1:0] w_alignMask;
  logic                  w_err;
  logic                  w_canAccept;
  logic                  w_accept;
  logic [BYTES-1:0]      w_be;
  logic                  w_unused;

  assign w_unused = htrans[0];

  // Address decode and legality checks operate on the live address-phase signals.
  assign w_offs      = haddr - BASE_ADDR;
  assign w_alignMask = ~({ADDR_WIDTH{1'b1}} << hsize);
  assign w_err       = (haddr < BASE_ADDR)
                     | ({1'b0, w_offs} >= MEM_BYTES)
                     | (hsize > 3'(OFF_W))
                     | (|(haddr & w_alignMask));

  assign w_canAccept = (r_state == ST_IDLE) | (r_state == ST_DATA) | (r_state == ST_ERR2);
  assign w_accept    = hsel & hready & htrans[1] & w_canAccept;
  assign w_launch    = w_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);

  always_ff @(posedge hclk) begin
    if (hreset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_WAIT: if (r_waitCnt <= WCNT_W'(1)) w_nextState = ST_DATA;
      ST_ERR1: w_nextState = ST_ERR2;
      default: w_nextState = w_accept ? w_launch : ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = r_rdata;
    case (r_state)
      ST_WAIT: hreadyout = 1'b0;
      ST_DATA: if (!r_write) hrdata = r_mem[r_idx];
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  // Capture the accepted address phase; the read word is latched so hrdata holds afterwards.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_idx     <= '0;
      r_off     <= '0;
      r_size    <= '0;
      r_write   <= 1'b0;
      r_waitCnt <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_idx     <= w_offs[OFF_W +: IDX_W];
        r_off     <= haddr[OFF_W-1:0];
        r_size    <= hsize;
        r_write   <= hwrite;
        r_waitCnt <= WCNT_W'(WAIT_STATES);
      end else if ((r_state == ST_WAIT) && (r_waitCnt != '0)) begin
        r_waitCnt <= r_waitCnt - WCNT_W'(1);
      end
      if ((r_state == ST_DATA) && !r_write) r_rdata <= r_mem[r_idx];
    end
  end

  always_comb begin
    w_be = '0;
    for (int i = 0; i < BYTES; i++) begin
      if ((i >= int'(r_off)) && (i < int'(r_off) + (1 << r_size))) w_be[i] = 1'b1;
    end
  end

  // Byte-lane write at the end of the data phase; a reset on that edge drops the write.
  always_ff @(posedge hclk) begin
    if (!hreset && (r_state == ST_DATA) && r_write) begin
      for (int i = 0; i < BYTES; i++) begin
        if (w_be[i]) r_mem[r_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: lane 0 runs with one wait state, lane 1 with none.
// A byte-array reference model predicts hreadyout/hresp/hrdata every cycle.
`timescale 1ns/1ps
module tb_ahb_sram_slave;

  localparam int          DEPTH = 1024;
  localparam int          MEMB  = DEPTH * 4;
  localparam logic [31:0] BASE  = 32'h0000_4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        sel   [2];
  logic [31:0] addr  [2];
  logic [1:0]  trans [2];
  logic        wr    [2];
  logic [2:0]  size  [2];
  logic [31:0] wdata [2];

  logic        rdyo0, rdyo1, resp0, resp1;
  logic [31:0] rdata0, rdata1;

  int tests = 0;
  int fails = 0;
  bit cmpOn = 1'b0;

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                   .BASE_ADDR(BASE), .WAIT_STATES(1)) dut0 (
    .hclk(clk), .hreset(rst[0]), .hsel(sel[0]), .haddr(addr[0]), .htrans(trans[0]),
    .hwrite(wr[0]), .hsize(size[0]), .hwdata(wdata[0]), .hready(rdyo0),
    .hreadyout(rdyo0), .hresp(resp0), .hrdata(rdata0));

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                   .BASE_ADDR(BASE), .WAIT_STATES(0)) dut1 (
    .hclk(clk), .hreset(rst[1]), .hsel(sel[1]), .haddr(addr[1]), .htrans(trans[1]),
    .hwrite(wr[1]), .hsize(size[1]), .hwdata(wdata[1]), .hready(rdyo1),
    .hreadyout(rdyo1), .hresp(resp1), .hrdata(rdata1));

  // Reference model: a transfer occupies mTotal response cycles; mLeft counts down.
  int          mLeft  [2];
  int          mTotal [2];
  int          mAddr  [2];
  int          mSize  [2];
  bit          mErr   [2];
  bit          mWr    [2];
  logic [31:0] mHold  [2];
  logic [7:0]  mMem   [2][MEMB];

  function automatic int waitsOf(int g);
    return (g == 0) ? 1 : 0;
  endfunction

  function automatic bit mReady(int g);
    if (mLeft[g] == 0) return 1'b1;
    if (mErr[g]) return (mTotal[g] - mLeft[g]) == 1;
    return mLeft[g] == 1;
  endfunction

  function automatic bit mResp(int g);
    return (mLeft[g] != 0) && mErr[g];
  endfunction

  function automatic logic [31:0] mWord(int g, int a);
    int w;
    w = a - (a % 4);
    return {mMem[g][w+3], mMem[g][w+2], mMem[g][w+1], mMem[g][w]};
  endfunction

  function automatic logic [31:0] mRdata(int g);
    if ((mLeft[g] == 1) && !mErr[g] && !mWr[g]) return mWord(g, mAddr[g]);
    return mHold[g];
  endfunction

  function automatic longint ofsOf(logic [31:0] a);
    return longint'(a) - longint'(BASE);
  endfunction

  function automatic bit isBad(logic [31:0] a, logic [2:0] sz);
    int nb;
    nb = 1 << sz;
    return (ofsOf(a) < 0) || (ofsOf(a) >= MEMB) || (nb > 4) || ((a % nb) != 0);
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g]) begin
        mLeft[g]  <= 0;
        mTotal[g] <= 0;
        mErr[g]   <= 1'b0;
        mHold[g]  <= '0;
      end else begin
        if ((mLeft[g] == 1) && !mErr[g]) begin
          if (mWr[g]) begin
            for (int b = 0; b < (1 << mSize[g]); b++)
              mMem[g][mAddr[g]+b] <= wdata[g][8*((mAddr[g]+b)%4) +: 8];
          end else begin
            mHold[g] <= mWord(g, mAddr[g]);
          end
        end
        if (mLeft[g] > 0) mLeft[g] <= mLeft[g] - 1;
        if (sel[g] && trans[g][1] && mReady(g)) begin
          mErr[g]   <= isBad(addr[g], size[g]);
          mWr[g]    <= wr[g];
          mSize[g]  <= int'(size[g]);
          mAddr[g]  <= isBad(addr[g], size[g]) ? 0 : int'(ofsOf(addr[g]));
          mTotal[g] <= isBad(addr[g], size[g]) ? 2 : waitsOf(g) + 1;
          mLeft[g]  <= isBad(addr[g], size[g]) ? 2 : waitsOf(g) + 1;
        end
      end
    end
  end

  function automatic logic getReady(int g);
    return (g == 0) ? rdyo0 : rdyo1;
  endfunction

  function automatic logic getResp(int g);
    return (g == 0) ? resp0 : resp1;
  endfunction

  function automatic logic [31:0] getRdata(int g);
    return (g == 0) ? rdata0 : rdata1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compareAll();
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("L%0d hreadyout", g), 32'(getReady(g)), 32'(mReady(g)));
      checkOutput($sformatf("L%0d hresp", g), 32'(getResp(g)), 32'(mResp(g)));
      checkOutput($sformatf("L%0d hrdata", g), getRdata(g), mRdata(g));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cmpOn) compareAll();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int g, input logic [31:0] a, input logic w,
                               input logic [2:0] sz, input logic [31:0] d,
                               output int nWait, output logic respFirst,
                               output logic respLast, output logic [31:0] rd);
    sel[g] = 1'b1; trans[g] = 2'b10; addr[g] = a; wr[g] = w; size[g] = sz;
    tick();
    sel[g] = 1'b0; trans[g] = 2'b00; wdata[g] = d;
    nWait = 0;
    respFirst = getResp(g);
    for (int k = 0; k < 40; k++) begin
      if (getReady(g)) break;
      nWait++;
      tick();
    end
    checkOutput($sformatf("L%0d handshake", g), 32'(getReady(g)), 32'd1);
    respLast = getResp(g);
    rd = getRdata(g);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          nw;
    logic        rf, rl;
    logic [31:0] rd;

    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; sel[g] = 1'b0; addr[g] = BASE; trans[g] = 2'b00;
      wr[g] = 1'b0; size[g] = 3'd2; wdata[g] = '0;
    end
    tick();
    cmpOn = 1'b1;
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();
    checkOutput("reset hreadyout", 32'(rdyo0), 32'd1);
    checkOutput("reset hresp", 32'(resp0), 32'd0);
    checkOutput("reset hrdata", rdata0, 32'h0);

    applyStimulus(0, BASE + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, nw, rf, rl, rd);
    checkOutput("ws1 write waits", 32'(nw), 32'd1);
    applyStimulus(0, BASE + 32'h10, 1'b0, 3'd2, 32'h0, nw, rf, rl, rd);
    checkOutput("ws1 read waits", 32'(nw), 32'd1);
    checkOutput("ws1 read data", rd, 32'hDEADBEEF);

    applyStimulus(0, BASE + 32'h10, 1'b1, 3'd2, 32'h11223344, nw, rf, rl, rd);
    applyStimulus(0, BASE + 32'h13, 1'b1, 3'd0, 32'hAA000000, nw, rf, rl, rd);
    applyStimulus(0, BASE + 32'h10, 1'b0, 3'd2, 32'h0, nw, rf, rl, rd);
    checkOutput("byte merge", rd, 32'hAA223344);
    checkOutput("model byte merge", mWord(0, 32'h10), 32'hAA223344);

    applyStimulus(0, BASE + MEMB, 1'b0, 3'd2, 32'h0, nw, rf, rl, rd);
    checkOutput("oor cycle1 hresp", 32'(rf), 32'd1);
    checkOutput("oor low-ready cycles", 32'(nw), 32'd1);
    checkOutput("oor cycle2 hresp", 32'(rl), 32'd1);
    applyStimulus(0, BASE + 32'h10, 1'b0, 3'd2, 32'h0, nw, rf, rl, rd);
    checkOutput("after err okay", 32'(rl), 32'd0);
    checkOutput("after err data", rd, 32'hAA223344);

    applyStimulus(0, BASE + 32'h18, 1'b1, 3'd2, 32'h55667788, nw, rf, rl, rd);
    applyStimulus(0, BASE + 32'h11, 1'b1, 3'd1, 32'hFFFFFFFF, nw, rf, rl, rd);
    checkOutput("misaligned err", 32'(rl), 32'd1);
    applyStimulus(0, BASE + 32'h18, 1'b1, 3'd3, 32'hFFFFFFFF, nw, rf, rl, rd);
    checkOutput("oversize err", 32'(rl), 32'd1);
    applyStimulus(0, BASE - 32'h4, 1'b0, 3'd2, 32'h0, nw, rf, rl, rd);
    checkOutput("below base err", 32'(rl), 32'd1);
    applyStimulus(0, BASE + 32'h10, 1'b0, 3'd2, 32'h0, nw, rf, rl, rd);
    checkOutput("misaligned untouched", rd, 32'hAA223344);
    applyStimulus(0, BASE + 32'h18, 1'b0, 3'd2, 32'h0, nw, rf, rl, rd);
    checkOutput("oversize untouched", rd, 32'h55667788);

    applyStimulus(1, BASE + 32'h80, 1'b1, 3'd1, 32'h0000BEEF, nw, rf, rl, rd);
    checkOutput("ws0 write waits", 32'(nw), 32'd0);
    sel[1] = 1'b1; trans[1] = 2'b10; addr[1] = BASE + 32'h40; wr[1] = 1'b1; size[1] = 3'd2;
    tick();
    checkOutput("b2b write ready", 32'(rdyo1), 32'd1);
    trans[1] = 2'b11; wr[1] = 1'b0; wdata[1] = 32'hCAFEF00D;
    tick();
    sel[1] = 1'b0; trans[1] = 2'b00;
    checkOutput("b2b read ready", 32'(rdyo1), 32'd1);
    checkOutput("b2b read data", rdata1, 32'hCAFEF00D);
    tick();
    applyStimulus(1, BASE + 32'h80, 1'b0, 3'd2, 32'h0, nw, rf, rl, rd);
    checkOutput("ws0 half read", rd[15:0], 32'h0000BEEF);

    applyStimulus(0, BASE + 32'h20, 1'b1, 3'd2, 32'h0BADF00D, nw, rf, rl, rd);
    sel[0] = 1'b1; trans[0] = 2'b10; addr[0] = BASE + 32'h20; wr[0] = 1'b1; size[0] = 3'd2;
    tick();
    sel[0] = 1'b0; trans[0] = 2'b00; wdata[0] = 32'h12345678;
    checkOutput("abort in wait", 32'(rdyo0), 32'd0);
    rst[0] = 1'b1;
    tick();
    checkOutput("abort idle ready", 32'(rdyo0), 32'd1);
    checkOutput("abort idle resp", 32'(resp0), 32'd0);
    rst[0] = 1'b0;
    tick();
    applyStimulus(0, BASE + 32'h20, 1'b0, 3'd2, 32'h0, nw, rf, rl, rd);
    checkOutput("aborted write dropped", rd, 32'h0BADF00D);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
